// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch PC with stall/flush/redirect and optional BTB + 2-bit predictor (BTB_PREDICT_EN)
module fetch_pc_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BTB_DEPTH = 16,
   parameter int              IDX_W     = $clog2(BTB_DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_target_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   output logic [XLEN-1:0] pc_o,
   output logic            valid_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_pc_o,
   output logic            flush_o
);
   localparam int TAG_W = XLEN - IDX_W - 2;
   logic [XLEN-1:0] pc_q, pc_plus4;
   logic            hold;
   assign pc_o     = pc_q;
   assign pc_plus4 = pc_q + XLEN'(4);
   assign hold     = !redirect_i && !jump_i && (stall_i || !start_i);
   assign flush_o  = rst_i & (redirect_i | jump_i);
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         pc_q    <= RESET_PC;
         valid_o <= 1'b0;
      end else begin
         pc_q    <= redirect_i ? redirect_pc_i : jump_i ? jump_target_i : hold ? pc_q : pred_pc_o;
         valid_o <= start_i & (redirect_i | jump_i | !stall_i);
      end
`ifdef BTB_PREDICT_EN
   logic [BTB_DEPTH-1:0] v_q;
   logic [1:0]           cnt_q [BTB_DEPTH];
   logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
   logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
   logic [IDX_W-1:0]     l_idx, u_idx;
   logic [TAG_W-1:0]     l_tag, u_tag;
   logic                 u_hit, unused_lsb;
   logic [1:0]           u_cnt;
   assign l_idx        = pc_q[IDX_W+1:2];
   assign l_tag        = pc_q[XLEN-1:IDX_W+2];
   assign u_idx        = upd_pc_i[IDX_W+1:2];
   assign u_tag        = upd_pc_i[XLEN-1:IDX_W+2];
   assign unused_lsb   = ^upd_pc_i[1:0];
   assign u_cnt        = cnt_q[u_idx];
   assign u_hit        = v_q[u_idx] && tag_q[u_idx] == u_tag;
   assign pred_taken_o = v_q[l_idx] && tag_q[l_idx] == l_tag && cnt_q[l_idx][1];
   assign pred_pc_o    = pred_taken_o ? tgt_q[l_idx] : pc_plus4;
   // not-taken misses never allocate; taken misses replace the entry weakly-taken
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         v_q <= '0;
         for (int i = 0; i < BTB_DEPTH; i++) cnt_q[i] <= 2'b01;
      end else if (upd_valid_i && (u_hit || upd_taken_i)) begin
         v_q[u_idx]   <= 1'b1;
         cnt_q[u_idx] <= !u_hit ? 2'b10 : upd_taken_i ? (u_cnt == 2'b11 ? u_cnt : u_cnt + 2'd1)
                                                      : (u_cnt == 2'b00 ? u_cnt : u_cnt - 2'd1);
      end
   always_ff @(posedge clk_i)
      if (upd_valid_i && upd_taken_i) begin
         tag_q[u_idx] <= u_tag;
         tgt_q[u_idx] <= upd_target_i;
      end
`else
   logic unused_upd;
   assign unused_upd   = ^{upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i};
   assign pred_taken_o = 1'b0;
   assign pred_pc_o    = pc_plus4;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: random + directed check of fetch_pc_unit against a behavioural model
module tb_fetch_pc_unit;
   localparam logic [31:0] RST_PC = 32'h100;
   localparam int DEPTH = 16;
`ifdef BTB_PREDICT_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif
   logic        clk = 0, rst_n = 0;
   logic        start = 0, stall = 0, jump = 0, redirect = 0, upd_valid = 0, upd_taken = 0;
   logic [31:0] jt = 0, rpc = 0, upd_pc = 0, upd_tgt = 0;
   logic [31:0] pc_o, pred_pc_o;
   logic        valid_o, pred_taken_o, flush_o;
   int          checks = 0, errors = 0;
   logic [31:0] m_pc;
   logic        m_valid;
   bit          m_bv [DEPTH];
   logic [31:0] m_bpc [DEPTH];
   logic [31:0] m_tgt [DEPTH];
   int          m_cnt [DEPTH];

   fetch_pc_unit #(.XLEN(32), .RESET_PC(RST_PC), .BTB_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .jump_i(jump),
      .jump_target_i(jt), .redirect_i(redirect), .redirect_pc_i(rpc),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken), .upd_target_i(upd_tgt),
      .pc_o(pc_o), .valid_o(valid_o), .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o), .flush_o(flush_o));

   always #5 clk = ~clk;

   function automatic int ix(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction
   function automatic bit m_hit(input logic [31:0] a);
      return m_bv[ix(a)] && (m_bpc[ix(a)] >> 6) == (a >> 6);
   endfunction
   function automatic bit m_taken();
      return BTB && m_hit(m_pc) && m_cnt[ix(m_pc)] >= 2;
   endfunction
   function automatic logic [31:0] m_pred_pc();
      return m_taken() ? m_tgt[ix(m_pc)] : m_pc + 32'd4;
   endfunction
   function automatic logic m_flush();
      return rst_n && (redirect || jump);
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_pc    <= RST_PC;
         m_valid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            m_bv[i]  <= 1'b0;
            m_cnt[i] <= 1;
         end
      end else begin
         m_pc    <= redirect ? rpc : jump ? jt : (stall || !start) ? m_pc : m_pred_pc();
         m_valid <= start && (redirect || jump || !stall);
         if (upd_valid) begin
            if (m_hit(upd_pc)) begin
               m_cnt[ix(upd_pc)] <= upd_taken ? (m_cnt[ix(upd_pc)] == 3 ? 3 : m_cnt[ix(upd_pc)] + 1)
                                              : (m_cnt[ix(upd_pc)] == 0 ? 0 : m_cnt[ix(upd_pc)] - 1);
               if (upd_taken) m_tgt[ix(upd_pc)] <= upd_tgt;
            end else if (upd_taken) begin
               m_bv[ix(upd_pc)]  <= 1'b1;
               m_bpc[ix(upd_pc)] <= upd_pc;
               m_tgt[ix(upd_pc)] <= upd_tgt;
               m_cnt[ix(upd_pc)] <= 2;
            end
         end
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl, input logic [31:0] exp);
      chk(nm, act, exp);
      chk({nm, "_model"}, mdl, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      chk("pc", pc_o, m_pc);
      chk("valid", 32'(valid_o), 32'(m_valid));
      chk("pred_taken", 32'(pred_taken_o), 32'(m_taken()));
      chk("pred_pc", pred_pc_o, m_pred_pc());
      chk("flush", 32'(flush_o), 32'(m_flush()));
   end

   initial begin
      redirect = 1; rpc = 32'h500;
      repeat (3) tick();
      lit("rst_pc", pc_o, m_pc, 32'h100);
      lit("rst_valid", 32'(valid_o), 32'(m_valid), 0);
      lit("rst_pred", 32'(pred_taken_o), 32'(m_taken()), 0);
      lit("rst_flush", 32'(flush_o), 32'(m_flush()), 0);
      redirect = 0; rst_n = 1; start = 1;
      #1 lit("rel_pc", pc_o, m_pc, 32'h100);
      tick(); lit("adv1", pc_o, m_pc, 32'h104); lit("adv1_v", 32'(valid_o), 32'(m_valid), 1);
      tick(); lit("adv2", pc_o, m_pc, 32'h108);
      stall = 1;
      tick(); lit("stall1", pc_o, m_pc, 32'h108); lit("stall1_v", 32'(valid_o), 32'(m_valid), 0);
      tick(); lit("stall2", pc_o, m_pc, 32'h108); lit("stall2_v", 32'(valid_o), 32'(m_valid), 0);
      stall = 0;
      tick(); lit("resume", pc_o, m_pc, 32'h10C); lit("resume_v", 32'(valid_o), 32'(m_valid), 1);
      jump = 1; jt = 32'h0040_0000; stall = 1;
      #1 lit("jmp_flush", 32'(flush_o), 32'(m_flush()), 1);
      tick(); lit("jmp_pc", pc_o, m_pc, 32'h0040_0000);
      stall = 0; jt = 32'h300; redirect = 1; rpc = 32'h200;
      #1 lit("rd_flush", 32'(flush_o), 32'(m_flush()), 1);
      tick(); lit("rd_prio", pc_o, m_pc, 32'h200);
      jump = 0; redirect = 0;
      upd_valid = 1; upd_taken = 1; upd_pc = 32'h40; upd_tgt = 32'h80;
      tick(); tick();
      upd_valid = 0; redirect = 1; rpc = 32'h40;
      tick();
      redirect = 0; stall = 1;
      #1 lit("btb_taken", 32'(pred_taken_o), 32'(m_taken()), 32'(BTB));
      lit("btb_ppc", pred_pc_o, m_pred_pc(), BTB ? 32'h80 : 32'h44);
      stall = 0;
      tick(); lit("btb_next", pc_o, m_pc, BTB ? 32'h80 : 32'h44);
      redirect = 1; rpc = 32'h40;
      tick();
      redirect = 0; stall = 1; upd_valid = 1; upd_taken = 0;
      #1 lit("nt_pre", 32'(pred_taken_o), 32'(m_taken()), 32'(BTB));
      tick(); lit("nt1", 32'(pred_taken_o), 32'(m_taken()), 32'(BTB));
      lit("nt1_ppc", pred_pc_o, m_pred_pc(), BTB ? 32'h80 : 32'h44);
      tick(); upd_valid = 0;
      lit("nt2", 32'(pred_taken_o), 32'(m_taken()), 0);
      lit("nt2_ppc", pred_pc_o, m_pred_pc(), 32'h44);
      upd_valid = 1; upd_taken = 1;
      tick();
      upd_valid = 0; redirect = 1; rpc = 32'h80;
      tick();
      redirect = 0;
      #1 lit("alias_taken", 32'(pred_taken_o), 32'(m_taken()), 0);
      lit("alias_ppc", pred_pc_o, m_pred_pc(), 32'h84);
      stall = 0; redirect = 1; rpc = 32'hFFFF_FFFC;
      tick(); redirect = 0;
      #1 lit("wrap_ppc", pred_pc_o, m_pred_pc(), 32'h0);
      tick(); lit("wrap_pc", pc_o, m_pc, 32'h0);
      stall = 1; redirect = 1; rpc = 32'h500;
      #1 rst_n = 0;
      #1 lit("mid_rst_pc", pc_o, m_pc, 32'h100);
      lit("mid_rst_v", 32'(valid_o), 32'(m_valid), 0);
      lit("mid_rst_flush", 32'(flush_o), 32'(m_flush()), 0);
      tick();
      rst_n = 1; redirect = 0; stall = 0;
      #1 lit("post_rst_pc", pc_o, m_pc, 32'h100);
      repeat (2000) begin
         tick();
         start     = $urandom_range(0, 9) != 0;
         stall     = $urandom_range(0, 4) == 0;
         jump      = $urandom_range(0, 9) == 0;
         redirect  = $urandom_range(0, 9) == 0;
         jt        = 32'($urandom_range(0, 63)) << 2;
         rpc       = 32'($urandom_range(0, 63)) << 2;
         upd_valid = $urandom_range(0, 4) < 2;
         upd_taken = $urandom_range(0, 2) != 0;
         upd_pc    = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
         upd_tgt   = 32'($urandom_range(0, 63)) << 2;
      end
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
